// File: rtl/plab1_idiv_pkg.sv
// Shared definitions for the variable-latency 32-bit unsigned divider:
// FSM state encoding and the fixed operand/message/count widths.
package plab1_idiv_pkg;

    localparam int OP_W  = 32;  // operand width
    localparam int MSG_W = 64;  // request/response message width
    localparam int CNT_W = 6;   // bits-remaining counter width (holds 0..32)
    localparam int LZ_W  = 4;   // leading-zero count width (holds 0..8)

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/plab1_idiv_var_latency_if.sv
// val/rdy request and response channels of the divider.
// master = source/sink harness side, slave = divider side.
interface plab1_idiv_var_latency_if;

    logic                              req_val;
    logic                              req_rdy;
    logic [plab1_idiv_pkg::MSG_W-1:0]  req_msg;   // {dividend, divisor}
    logic                              resp_val;
    logic                              resp_rdy;
    logic [plab1_idiv_pkg::MSG_W-1:0]  resp_msg;  // {remainder, quotient}

    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/plab1_idiv_count_leading_zeros8.sv
// Leading-zero counter for one byte: 8 for an all-zero byte, otherwise the
// index of the first 1 counted from the MSB.
module plab1_idiv_count_leading_zeros8
    import plab1_idiv_pkg::*;
(
    input  logic [7:0]      i_byte,
    output logic [LZ_W-1:0] o_lz
);

    // Scan LSB to MSB so the most significant set bit is the last one to win.
    always_comb begin
        o_lz = LZ_W'(8);
        for (int i = 0; i < 8; i++) begin
            if (i_byte[i]) begin
                o_lz = LZ_W'(7 - i);
            end
        end
    end

endmodule

// File: rtl/plab1_idiv_var_latency.sv
// Iterative 32-bit unsigned divider. NORM skips leading zeros of the
// dividend up to 8 bits per cycle; DIV then retires one quotient bit per
// cycle by restoring division.
module plab1_idiv_var_latency
    import plab1_idiv_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,   // asynchronous, active-low
    plab1_idiv_var_latency_if.slave idiv
);

    // ---------------------------------------------------------------- datapath
    state_t           r_state;
    state_t           w_state_nxt;

    logic [OP_W-1:0]  r_dvd, r_dsr, r_rem, r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0]  w_dvd_nxt, w_dsr_nxt, w_rem_nxt, w_quo_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [OP_W-1:0]  w_a, w_b;
    logic [LZ_W-1:0]  w_lz;
    logic [CNT_W-1:0] w_lz_ext, w_sh;
    logic [OP_W:0]    w_t;
    logic             w_q_bit;
    logic             w_req_go, w_resp_go;
    logic             w_cnt_zero, w_lz_full;

    assign w_a = idiv.req_msg[MSG_W-1:OP_W];
    assign w_b = idiv.req_msg[OP_W-1:0];

    plab1_idiv_count_leading_zeros8 u_clz (
        .i_byte (r_dvd[OP_W-1:OP_W-8]),
        .o_lz   (w_lz)
    );

    // Normalisation shift never exceeds the bits still to be processed.
    assign w_lz_ext = CNT_W'(w_lz);
    assign w_sh     = (w_lz_ext < r_cnt) ? w_lz_ext : r_cnt;

    // The restoring subtract keeps the remainder below the divisor, so the
    // remainder register needs only 32 bits; bit 32 lives only in the trial value.
    assign w_t     = {r_rem, r_dvd[OP_W-1]};
    assign w_q_bit = (w_t >= {1'b0, r_dsr});

    assign w_req_go  = idiv.req_val  && idiv.req_rdy;
    assign w_resp_go = idiv.resp_val && idiv.resp_rdy;

    // Next values of the data registers for each state.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_dvd_nxt = r_dvd;
        w_dsr_nxt = r_dsr;
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_cnt_nxt = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req_go) begin
                    w_dvd_nxt = w_a;
                    w_dsr_nxt = w_b;
                    w_rem_nxt = '0;
                    w_quo_nxt = '0;
                    w_cnt_nxt = CNT_W'(OP_W);
                    // Divide by zero: the result is final at once. A zero
                    // count makes the single NORM pass shift by 0 and exit,
                    // which gives the one-cycle latency.
                    if (w_b == '0) begin
                        w_quo_nxt = '1;
                        w_rem_nxt = w_a;
                        w_cnt_nxt = '0;
                    end
                end
            end
            ST_NORM: begin
                w_dvd_nxt = r_dvd << w_sh;
                w_cnt_nxt = r_cnt - w_sh;
            end
            ST_DIV: begin
                w_rem_nxt = w_q_bit ? (w_t[OP_W-1:0] - r_dsr) : w_t[OP_W-1:0];
                w_quo_nxt = {r_quo[OP_W-2:0], w_q_bit};
                w_dvd_nxt = r_dvd << 1;
                w_cnt_nxt = r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Data registers; all cleared while reset is low.
    // NOTE: data registers get an explicit reset here because reset must also abort any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dvd <= '0;
            r_dsr <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_dvd <= w_dvd_nxt;
            r_dsr <= w_dsr_nxt;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign idiv.resp_msg = {r_rem, r_quo};

    // ----------------------------------------------------------------- control
    assign w_cnt_zero = (w_cnt_nxt == '0);
    assign w_lz_full  = (w_lz == LZ_W'(8));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs decoded from the state only.
    always_comb begin
        w_state_nxt   = r_state;
        idiv.req_rdy  = 1'b0;
        idiv.resp_val = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                idiv.req_rdy = reset;
                if (w_req_go) begin
                    w_state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end else if (!w_lz_full) begin
                    w_state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                idiv.resp_val = 1'b1;
                if (w_resp_go) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_plab1_idiv_var_latency.sv
// Bench for plab1_idiv_var_latency: directed cases, backpressure, reset abort
// and randomized traffic against a plain-arithmetic reference model.
module tb_plab1_idiv_var_latency;

    typedef struct {
        logic [63:0] msg;   // expected {remainder, quotient}
        int          acc;   // accept edge number
        int          lat;   // expected latency in cycles
    } exp_t;

    logic clk;
    logic reset;

    plab1_idiv_var_latency_if idiv_if ();

    plab1_idiv_var_latency dut (
        .clk   (clk),
        .reset (reset),
        .idiv  (idiv_if)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    exp_t sb[$];

    logic        hold_low   = 1'b0;  // force resp_rdy low
    logic        rand_stall = 1'b0;  // randomize resp_rdy
    logic        seen       = 1'b0;  // current response already observed
    int          first_cyc  = 0;
    logic [63:0] held_msg   = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: quotient/remainder by plain arithmetic; latency from the
    // leading-zero count L: L/8+1 normalise passes then 32-L quotient bits.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   p;
        int   lz;
        e.acc = 0;
        if (b == 0) begin
            e.msg = {a, 32'hFFFF_FFFF};
            e.lat = 1;
        end else begin
            e.msg = {a % b, a / b};
            if (a == 0) begin
                e.lat = 4;
            end else begin
                p = 31;
                while (((a >> p) & 32'd1) == 0) p--;
                lz    = 31 - p;
                e.lat = lz / 8 + 1 + (32 - lz);
            end
        end
        return e;
    endfunction

    // Sink-side ready generator.
    initial begin
        idiv_if.resp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low)        idiv_if.resp_rdy = 1'b0;
            else if (rand_stall) idiv_if.resp_rdy = ($urandom_range(0, 3) != 0);
            else                 idiv_if.resp_rdy = 1'b1;
        end
    end

    // Monitor: latency capture, hold-stability, and scoreboard pop on transfer.
    always @(negedge clk) begin
        if (!reset) begin
            seen = 1'b0;
        end else if (idiv_if.resp_val) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
                held_msg  = idiv_if.resp_msg;
            end else begin
                check("resp_msg_stable", idiv_if.resp_msg, held_msg);
            end
            if (idiv_if.resp_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_msg", idiv_if.resp_msg, e.msg);
                    check("latency", 64'(first_cyc - e.acc), 64'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    // Offer one request; push its expectation on the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int waited = 0;
        idiv_if.req_val = 1'b1;
        idiv_if.req_msg = {a, b};
        forever begin
            @(negedge clk);
            if (idiv_if.req_rdy) break;
            if (++waited > 500) break;
        end
        if (waited > 500) begin
            check("req_accept_timeout", 64'd0, 64'd1);
        end else begin
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        idiv_if.req_val = 1'b0;
    endtask

    task automatic send_dir(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] q, input logic [31:0] r, input int lat);
        exp_t e;
        e.msg = {r, q};
        e.lat = lat;
        e.acc = 0;
        send(a, b, e);
    endtask

    // Wait until every expected response has been consumed.
    task automatic drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int          waited;

        reset           = 1'b0;
        idiv_if.req_val = 1'b0;
        idiv_if.req_msg = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_rdy", 64'(idiv_if.req_rdy), 64'd0);
        check("rst_resp_val", 64'(idiv_if.resp_val), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_req_rdy", 64'(idiv_if.req_rdy), 64'd1);
        check("idle_resp_val", 64'(idiv_if.resp_val), 64'd0);
        @(posedge clk);
        #1;

        // Directed cases
        send_dir(32'd100, 32'd7, 32'd14, 32'd2, 11);
        drain();
        send_dir(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        drain();
        send_dir(32'd0, 32'd5, 32'd0, 32'd0, 4);
        drain();
        send_dir(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
        drain();

        // Backpressure: held response must stay put with req_rdy low
        hold_low = 1'b1;
        @(posedge clk);
        #2;
        send_dir(32'd50, 32'd8, 32'd6, 32'd2, 10);
        waited = 0;
        while (!idiv_if.resp_val && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("bp_resp_val_seen", 64'(idiv_if.resp_val), 64'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_resp_val", 64'(idiv_if.resp_val), 64'd1);
            check("bp_req_rdy", 64'(idiv_if.req_rdy), 64'd0);
            check("bp_resp_msg", idiv_if.resp_msg, {32'd2, 32'd6});
        end
        hold_low = 1'b0;
        drain();
        @(negedge clk);
        check("bp_idle_req_rdy", 64'(idiv_if.req_rdy), 64'd1);
        check("bp_idle_resp_val", 64'(idiv_if.resp_val), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of DIV aborts without a response
        send_dir(32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 33);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        check("abort_resp_val", 64'(idiv_if.resp_val), 64'd0);
        check("abort_req_rdy", 64'(idiv_if.req_rdy), 64'd0);
        @(negedge clk);
        check("abort_hold_resp_val", 64'(idiv_if.resp_val), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_req_rdy", 64'(idiv_if.req_rdy), 64'd1);
        @(posedge clk);
        #1;
        send_dir(32'd9, 32'd3, 32'd3, 32'd0, 8);
        drain();

        // Randomized traffic with request gaps and sink stalls
        rand_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = $urandom >> $urandom_range(8, 31); b = $urandom; end
                2: begin a = 32'd0; b = $urandom | 32'd1; end
                3: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
                default: begin
                    a = $urandom >> $urandom_range(0, 31);
                    b = $urandom >> $urandom_range(0, 31);
                end
            endcase
            send(a, b, model(a, b));
        end
        drain();
        rand_stall = 1'b0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
